alarm_tone_sequencer: RTL and testbench

//  Parametrised square-wave melody engine for the alarm path. Walks a note table
//  (period/duration pairs, external combinational ROM) under start/stop control,

---
 rtl/alarm_tone_sequencer_if.sv | 13 +
 rtl/alarm_tone_sequencer.sv | 133 +++++++++++++
 tb/tb_alarm_tone_sequencer.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/alarm_tone_sequencer_if.sv
// rtl/alarm_tone_sequencer_if.sv - note-table ROM bus between the tone sequencer and its song ROM
interface alarm_tone_sequencer_if #(
  parameter int PER_W = 20,
  parameter int DUR_W = 5,
  parameter int IDX_W = 6
) ();
  logic [IDX_W-1:0] note_idx;
  logic [PER_W-1:0] note_period;
  logic [DUR_W-1:0] note_dur;

  modport master (output note_idx, input note_period, input note_dur);
  modport slave  (input note_idx, output note_period, output note_dur);
endinterface

// File: rtl/alarm_tone_sequencer.sv
// rtl/alarm_tone_sequencer.sv - note-table driven square-wave melody engine for the alarm audio path
module alarm_tone_sequencer #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int PER_W     = 20,
  parameter int DUR_W     = 5,
  parameter int IDX_W     = 6,
  parameter int GAP_TICKS = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  loop_en,
  input  logic [IDX_W-1:0]      seq_len,
  alarm_tone_sequencer_if.master rom,
  output logic                  audio_out,
  output logic                  aud_sd,
  output logic                  busy,
  output logic                  done
);
  localparam int TICK_DIV = (CLK_HZ / 8 > 1) ? CLK_HZ / 8 : 1;
  localparam int PRESC_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GAP_W    = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  localparam int TCNT_W   = (GAP_W > DUR_W) ? GAP_W : DUR_W;
  localparam int GAP_LAST = (GAP_TICKS > 0) ? GAP_TICKS - 1 : 0;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_PLAY = 3'd2,
    S_GAP  = 3'd3,
    S_ADV  = 3'd4,
    S_END  = 3'd5
  } state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   note_idx;
  logic [PER_W-1:0]   lat_per, hp_cnt;
  logic [DUR_W-1:0]   lat_dur, dur_last;
  logic [PRESC_W-1:0] presc;
  logic [TCNT_W-1:0]  tick_cnt;
  logic               tick, tone_edge, note_over, gap_over, at_last, done_nxt;

  assign rom.note_idx = note_idx;
  assign dur_last     = lat_dur - DUR_W'(1);
  assign tick         = (presc == PRESC_LAST);
  assign tone_edge    = (lat_per != '0) && (hp_cnt == lat_per - PER_W'(1));
  assign note_over    = tick && (tick_cnt == TCNT_W'(dur_last));
  assign gap_over     = tick && (tick_cnt == TCNT_W'(GAP_LAST));
  // >= rather than == keeps note_idx in range if seq_len shrinks mid-song
  assign at_last      = (note_idx >= seq_len);

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    if (state != S_IDLE && stop) begin
      state_nxt = S_IDLE;
      done_nxt  = 1'b1;
    end else begin
      case (state)
        S_IDLE: if (start && !stop) state_nxt = S_LOAD;
        S_LOAD: state_nxt = (rom.note_dur == '0) ? S_END : S_PLAY;
        S_PLAY: if (note_over) state_nxt = (GAP_TICKS > 0) ? S_GAP : S_ADV;
        S_GAP:  if (gap_over) state_nxt = S_ADV;
        S_ADV:  state_nxt = at_last ? S_END : S_LOAD;
        S_END: begin
          if (loop_en) begin
            state_nxt = S_LOAD;
          end else begin
            state_nxt = S_IDLE;
            done_nxt  = 1'b1;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      note_idx  <= '0;
      lat_per   <= '0;
      lat_dur   <= '0;
      hp_cnt    <= '0;
      presc     <= '0;
      tick_cnt  <= '0;
      audio_out <= 1'b0;
      aud_sd    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state  <= state_nxt;
      done   <= done_nxt;
      busy   <= (state_nxt != S_IDLE);
      aud_sd <= (state_nxt != S_IDLE);

      if (state_nxt == S_LOAD) begin
        if (state == S_ADV) note_idx <= note_idx + IDX_W'(1);
        else                note_idx <= '0;
      end

      case (state)
        S_LOAD: begin
          lat_per   <= rom.note_period;
          lat_dur   <= rom.note_dur;
          hp_cnt    <= '0;
          presc     <= '0;
          tick_cnt  <= '0;
          audio_out <= 1'b0;
        end
        S_PLAY, S_GAP: begin
          // prescaler keeps running into GAP so the gap is whole ticks too
          presc <= tick ? '0 : presc + PRESC_W'(1);
          if (state_nxt != state) tick_cnt <= '0;
          else if (tick)          tick_cnt <= tick_cnt + TCNT_W'(1);
          if (state == S_PLAY && state_nxt == S_PLAY) begin
            if (tone_edge) begin
              hp_cnt    <= '0;
              audio_out <= ~audio_out;
            end else if (lat_per != '0) begin
              hp_cnt <= hp_cnt + PER_W'(1);
            end
          end else begin
            audio_out <= 1'b0;
          end
        end
        default: audio_out <= 1'b0;
      endcase
    end
  end
endmodule

// File: tb/tb_alarm_tone_sequencer.sv
// tb/tb_alarm_tone_sequencer.sv - scoreboard bench for alarm_tone_sequencer against a note timeline model
module tb_alarm_tone_sequencer;
  localparam int CLK_HZ    = 800;
  localparam int PER_W     = 8;
  localparam int DUR_W     = 3;
  localparam int IDX_W     = 3;
  localparam int GAP_TICKS = 1;
  localparam int TICK      = CLK_HZ / 8;

  typedef struct {
    int unsigned t;
    int          v;
  } ev_t;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             loop_en = 1'b0;
  logic [IDX_W-1:0] seq_len = '0;
  logic             audio_out, aud_sd, busy, done;

  logic [PER_W-1:0] rom_per [8];
  logic [DUR_W-1:0] rom_dur [8];

  int unsigned cyc = 0;
  int          total = 0;
  int          bad = 0;
  int          model_idx = 0;
  bit          mon_en = 1'b0;
  logic        prev_aud = 1'b0;
  logic [IDX_W-1:0] prev_idx = '0;

  ev_t aud_q[$];
  ev_t idx_q[$];
  ev_t done_q[$];

  alarm_tone_sequencer_if #(.PER_W(PER_W), .DUR_W(DUR_W), .IDX_W(IDX_W)) rif ();

  assign rif.note_period = rom_per[rif.note_idx];
  assign rif.note_dur    = rom_dur[rif.note_idx];

  alarm_tone_sequencer #(
    .CLK_HZ(CLK_HZ), .PER_W(PER_W), .DUR_W(DUR_W), .IDX_W(IDX_W), .GAP_TICKS(GAP_TICKS)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .loop_en(loop_en),
    .seq_len(seq_len), .rom(rif), .audio_out(audio_out), .aud_sd(aud_sd),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic extra(input string name, input int val);
    total++;
    bad++;
    $display("FAIL %s: actual=%0d required=no event (cycle %0d)", name, val, cyc);
  endtask

  // Expected timeline: edge numbers at which audio/note_idx change and done pulses.
  task automatic model_song(input int unsigned s0, input bit lp, input int slen,
                            input int unsigned stop_t, output int unsigned last_t);
    int unsigned t, tn;
    int idx, p, d;
    bit lvl, fin;
    lvl = 1'b0; fin = 1'b0; idx = 0; t = s0;
    if (model_idx != 0) idx_q.push_back('{t: s0, v: 0});
    model_idx = 0;
    while (!fin && t < stop_t) begin
      t = t + 1;
      p = int'(rom_per[idx]);
      d = int'(rom_dur[idx]);
      if (d != 0) begin
        tn = t + d * TICK;
        if (p != 0)
          for (int unsigned k = t + p; k < tn; k = k + p)
            if (k < stop_t) begin
              lvl = !lvl;
              aud_q.push_back('{t: k, v: int'(lvl)});
            end
        if (lvl && tn < stop_t) begin
          lvl = 1'b0;
          aud_q.push_back('{t: tn, v: 0});
        end
        t = tn + GAP_TICKS * TICK + 1;
        if (idx < slen) begin
          idx++;
          if (t < stop_t) begin
            idx_q.push_back('{t: t, v: idx});
            model_idx = idx;
          end
          continue;
        end
      end
      t = t + 1;
      if (!lp) fin = 1'b1;
      else if (t < stop_t) begin
        if (idx != 0) idx_q.push_back('{t: t, v: 0});
        idx = 0;
        model_idx = 0;
      end
    end
    if (fin && t < stop_t) begin
      done_q.push_back('{t: t, v: model_idx});
      last_t = t;
    end else begin
      if (lvl) aud_q.push_back('{t: stop_t, v: 0});
      done_q.push_back('{t: stop_t, v: -1});
      last_t = stop_t;
    end
  endtask

  task automatic run_song(input bit lp, input int slen, input int stop_after);
    int unsigned s0, stop_t, last_t;
    int berr;
    @(negedge clk);
    loop_en = lp;
    seq_len = IDX_W'(slen);
    start = 1'b1;
    s0 = cyc + 1;
    stop_t = (stop_after > 0) ? s0 + stop_after : 32'hFFFF_FFFF;
    model_song(s0, lp, slen, stop_t, last_t);
    berr = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      stop = (cyc + 1 == stop_t);
      if (busy !== (cyc < last_t) || aud_sd !== (cyc < last_t)) berr++;
    end while (cyc < last_t + 3);
    stop = 1'b0;
    chk("busy_window", 32'(berr), 0);
    chk("audio_events_left", 32'(aud_q.size()), 0);
    chk("idx_events_left", 32'(idx_q.size()), 0);
    chk("done_events_left", 32'(done_q.size()), 0);
  endtask

  task automatic set_note(input int i, input int p, input int d);
    rom_per[i] = PER_W'(p);
    rom_dur[i] = DUR_W'(d);
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (mon_en && reset) begin
      if (audio_out !== prev_aud) begin
        if (aud_q.size() == 0) extra("audio_edge", int'(audio_out));
        else begin
          e = aud_q.pop_front();
          chk("audio_edge_time", cyc, e.t);
          chk("audio_edge_level", 32'(audio_out), 32'(e.v));
        end
      end
      if (rif.note_idx !== prev_idx) begin
        if (idx_q.size() == 0) extra("note_idx_change", int'(rif.note_idx));
        else begin
          e = idx_q.pop_front();
          chk("note_idx_time", cyc, e.t);
          chk("note_idx_value", 32'(rif.note_idx), 32'(e.v));
        end
      end
      if (done) begin
        if (done_q.size() == 0) extra("done_pulse", 1);
        else begin
          e = done_q.pop_front();
          chk("done_time", cyc, e.t);
          chk("done_busy_low", 32'(busy), 0);
          chk("done_aud_sd_low", 32'(aud_sd), 0);
          if (e.v >= 0) chk("done_note_idx", 32'(rif.note_idx), 32'(e.v));
        end
      end
    end
    prev_aud = audio_out;
    prev_idx = rif.note_idx;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int berr;
    for (int i = 0; i < 8; i++) set_note(i, 0, 0);
    repeat (3) @(negedge clk);
    chk("reset_audio_out", 32'(audio_out), 0);
    chk("reset_aud_sd", 32'(aud_sd), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_note_idx", 32'(rif.note_idx), 0);
    reset = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;

    set_note(0, 5, 2);
    set_note(1, 3, 1);
    run_song(1'b0, 1, 0);
    run_song(1'b1, 1, 1300);

    set_note(0, 4, 1);
    set_note(1, 7, 0);
    run_song(1'b0, 5, 0);

    set_note(0, 0, 2);
    set_note(1, 3, 1);
    run_song(1'b0, 1, 0);

    set_note(0, 2, 1);
    run_song(1'b0, 0, 0);

    @(negedge clk);
    start = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop = 1'b0;
    berr = 0;
    repeat (6) begin
      @(negedge clk);
      if (busy !== 1'b0 || audio_out !== 1'b0) berr++;
    end
    chk("stop_with_start_idle", 32'(berr), 0);

    set_note(0, 5, 2);
    run_song(1'b0, 1, 42);

    mon_en = 1'b0;
    @(negedge clk);
    seq_len = 1;
    loop_en = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    chk("pre_reset_busy", 32'(busy), 1);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_audio_out", 32'(audio_out), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_aud_sd", 32'(aud_sd), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_note_idx", 32'(rif.note_idx), 0);
    end
    reset = 1'b1;
    model_idx = 0;
    @(negedge clk);
    @(negedge clk);
    chk("post_reset_idle", 32'(busy), 0);
    mon_en = 1'b1;

    for (int r = 0; r < 10; r++) begin
      bit lp;
      int slen, sa;
      for (int i = 0; i < 8; i++) begin
        rom_per[i] = ($urandom_range(0, 4) == 0) ? '0 : PER_W'($urandom_range(1, 9));
        rom_dur[i] = ($urandom_range(0, 9) == 0) ? '0 : DUR_W'($urandom_range(1, 2));
      end
      lp = ($urandom_range(0, 3) == 0);
      slen = int'($urandom_range(0, 5));
      if (lp) sa = int'($urandom_range(50, 1500));
      else sa = ($urandom_range(0, 2) == 0) ? int'($urandom_range(5, 600)) : 0;
      run_song(lp, slen, sa);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
